pixel_receiver: RTL
===================

// Module: pixel_receiver
// PURPOSE
//   WS2812B-style serial decoder: the receive end of the single-wire LED protocol our pixel transmitter drives.
//   Samples din, measures each high-pulse width to decode bits MSB-first in G->R->B order, and assembles 24-bit pixels.
//   Detects the long-low reset gap that marks a frame boundary. Presents pixels on a valid/ready output handshake.
//   Used for loopback self-test of the LED chain and as the input stage of a daisy-chain bridge.
// PARAMETERS
//   CLK_HZ        16000000  system clock frequency; documentation only, all timing is in ticks
//   CNT_COLOR     24        bits per pixel
//   TCK_MIN_HI    3         high pulses shorter than this (ticks) are glitches -> error
//   TCK_THRESH    9         high width >= TCK_THRESH decodes as 1, otherwise 0 (nominal 0=6, 1=11)
//   TCK_MAX_HI    16        high width > TCK_MAX_HI -> error
//   TCK_RESET_MIN 800       line low for this many ticks = reset gap / frame end
// PORTS
//   clk       in   1  system clock; all logic on posedge
//   reset     in   1  asynchronous, active-high reset
//   din       in   1  serial data line, asynchronous to clk
//   green     out  8  decoded pixel, first byte received
//   red       out  8  decoded pixel, second byte
//   blue      out  8  decoded pixel, third byte
//   first     out  1  qualifies current pixel: first pixel after a reset gap
//   valid     out  1  pixel/first outputs hold a pixel
//   ready     in   1  consumer accepts the pixel when valid && ready
//   overflow  out  1  1-cycle pulse: completed pixel dropped because the buffer was full
//   error     out  1  1-cycle pulse: framing/pulse-width violation, partial pixel discarded
//   in_gap    out  1  high while the line is in a qualified reset gap (idle)
// BEHAVIOUR
//   Reset values: valid=0, first=0, colours=0, overflow=0, error=0, in_gap=0, state=SYNC, all counters=0.
//   din passes a 2-FF synchronizer, then a 1-FF edge detect. All timing below is on the synchronized signal (ds).
//   Tick counter: width $clog2(TCK_RESET_MIN+1); saturates at TCK_RESET_MIN; clears on every ds edge.
//   Bit counter: $clog2(CNT_COLOR) bits. Shift register: CNT_COLOR bits, shifted left with LSB insert.
//   States:
//     SYNC    wait for ds low TCK_RESET_MIN consecutive ticks -> GAP; ds high restarts the count.
//             Entered after reset and after any error, so the receiver never decodes mid-frame data.
//     GAP     in_gap=1; first_pend=1; bitcnt=0. Rising edge -> HI.
//     HI      count high ticks. On falling edge, decode the bit:
//               hi < TCK_MIN_HI or hi > TCK_MAX_HI -> error pulse, go SYNC.
//               otherwise shift in (hi >= TCK_THRESH), go LO.
//             If hi exceeds TCK_MAX_HI while still high -> error, go SYNC (stuck-high line).
//     LO      count low ticks. Rising edge -> HI.
//             Low reaching TCK_RESET_MIN -> GAP; if bitcnt != 0 at that moment -> error pulse (partial pixel dropped).
//   Pixel completion: on the decode of bit CNT_COLOR-1, bitcnt wraps to 0 and the pixel word is complete.
//     If the buffer is free, or being accepted this cycle (valid && ready): load {green,red,blue} and first=first_pend,
//       clear first_pend, set valid on the next cycle.
//     Else: overflow pulse; held pixel is unchanged; first_pend is cleared.
//   Latency: valid rises 4 clk after the raw din falling edge of the 24th bit (2 sync + 1 edge + 1 register).
//   Handshake: outputs are stable while valid && !ready. valid drops the cycle after acceptance unless a pixel completes
//     in the same cycle; a pixel completing in the accept cycle is loaded with no gap and no overflow.
//   error and overflow never assert in the same cycle. Async reset mid-frame: everything clears, state returns to SYNC.
// STRUCTURE
//   pixel_pkg: CNT_COLOR, nominal tick constants shared with the transmitter (TCK_ZR_HI=6, TCK_ON_HI=11,
//     TCK_COLOR=18), state encodings SYNC/GAP/HI/LO.
//   Sub-module din_sync: 2-FF synchronizer plus edge detect; outputs ds, rise, fall. Everything else lives in this file.
// TESTING
//   1. Reset, hold din low 800 clk, send 24 bits of 0xA5_3C_0F (hi 11/6, period 18) -> green=A5 red=3C blue=0F, first=1, valid.
//   2. Two back-to-back pixels, ready=1 -> second pixel has first=0. Low gap of 800, then a third -> first=1.
//   3. Hold ready=0 across two pixels -> first pixel stays on outputs, overflow pulses once; after ready, no stale second pixel.
//   4. 2-tick high glitch mid-pixel -> error pulse; next pixel is ignored until an 800-tick gap, then decodes correctly.
//   5. Stop after 10 bits, line low 800 -> error pulse, in_gap=1, no valid; following full pixel decodes with first=1.
//   6. Assert reset mid-pixel with valid=1 -> valid=0 immediately; bits sent without a prior 800-tick gap are not decoded.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared constants and receiver state encoding for the single-wire pixel link.
// Latency: none, constants and types only.
// Backpressure: not applicable.
// Contents: pixel width, nominal transmitter tick widths, receiver FSM states.
package pixel_pkg;

    // Bits per pixel: green, red, blue bytes, MSB first.
    localparam int CNT_COLOR = 24;

    // Nominal transmitter timing in clock ticks. A zero bit is high for
    // TCK_ZR_HI ticks, a one bit for TCK_ON_HI ticks, and each bit lasts
    // TCK_COLOR ticks in total.
    localparam int TCK_ZR_HI = 6;
    localparam int TCK_ON_HI = 11;
    localparam int TCK_COLOR = 18;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,  // waiting for a reset gap before trusting the line
        ST_GAP  = 2'd1,  // line idle in a qualified reset gap
        ST_HI   = 2'd2,  // measuring a high pulse
        ST_LO   = 2'd3   // measuring the low time between pulses
    } rx_state_t;

endpackage

// File: rtl/pixel_receiver_din_sync.sv
// Synchronizes the asynchronous serial line and flags its edges.
// Latency: ds, rise and fall appear 3 clk after a raw din change (2 sync + 1 edge).
// Backpressure: none, free-running.
// Ports: clk, reset (async, active high), din (raw line) -> ds (synchronized level),
//        rise/fall (one-cycle pulses on the first cycle ds shows the new level).
module din_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic ds,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic ds_q, ds_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Edge flags are registered alongside ds so a pulse marks exactly the
    // first cycle in which ds carries the new level.
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        ds_d   = s2_q;
        rise_d = s2_q & ~ds_q;
        fall_d = ~s2_q & ds_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            ds_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            ds_q   <= ds_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign ds   = ds_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/pixel_receiver.sv
// Decodes the WS2812B-style single-wire stream into 24-bit G/R/B pixels and detects frame gaps.
// Latency: valid rises 4 clk after the raw din falling edge of a pixel's last bit.
// Backpressure: one-pixel output buffer held while valid && !ready; a pixel completing while full is dropped with an overflow pulse.
// Ports: clk, reset (async, active high), din (raw line); green/red/blue/first/valid out with ready in;
//        overflow and error one-cycle pulses; in_gap high while the line sits in a qualified reset gap.
module pixel_receiver
    import pixel_pkg::*;
#(
    parameter int CLK_HZ        = 16000000,
    parameter int TCK_MIN_HI    = TCK_ZR_HI / 2,
    parameter int TCK_THRESH    = (TCK_ZR_HI + TCK_ON_HI + 1) / 2,
    parameter int TCK_MAX_HI    = TCK_COLOR - 2,
    parameter int TCK_RESET_MIN = CLK_HZ / 20000   // 50 us of low line
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [7:0] green,
    output logic [7:0] red,
    output logic [7:0] blue,
    output logic       first,
    output logic       valid,
    input  logic       ready,
    output logic       overflow,
    output logic       error,
    output logic       in_gap
);

    localparam int CW = $clog2(TCK_RESET_MIN + 1);
    localparam int BW = $clog2(CNT_COLOR);

    localparam logic [CW-1:0] MIN_HI_C    = CW'(TCK_MIN_HI);
    localparam logic [CW-1:0] THRESH_C    = CW'(TCK_THRESH);
    localparam logic [CW-1:0] MAX_HI_C    = CW'(TCK_MAX_HI);
    localparam logic [CW-1:0] RESET_MIN_C = CW'(TCK_RESET_MIN);
    localparam logic [BW-1:0] LAST_BIT_C  = BW'(CNT_COLOR - 1);

    logic ds, rise, fall;

    din_sync u_din_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .ds    (ds),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_t state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    // The final bit of a pixel goes straight to the output registers, so only
    // the first CNT_COLOR-1 bits are ever held here.
    logic [CNT_COLOR-2:0] sr_q, sr_d;
    logic                 first_pend_q, first_pend_d;
    logic                 valid_q, valid_d;
    logic                 first_q, first_d;
    logic [7:0]           green_q, green_d;
    logic [7:0]           red_q, red_d;
    logic [7:0]           blue_q, blue_d;
    logic                 error_q, error_d;
    logic                 overflow_q, overflow_d;

    logic [CW-1:0]        run;      // length of the current ds level including this cycle
    logic                 bit_val;
    logic                 done;
    logic [CNT_COLOR-1:0] word;

    always_comb begin
        // On an edge cnt_q still holds the length of the level that just ended,
        // which is exactly the pulse width the HI state needs to judge.
        run = cnt_q;
        if (rise || fall) begin
            run = CW'(1);
        end else if (cnt_q != RESET_MIN_C) begin
            run = cnt_q + CW'(1);
        end
        cnt_d = run;

        bit_val = (cnt_q >= THRESH_C);
        word    = {sr_q, bit_val};
        done    = 1'b0;

        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        sr_d         = sr_q;
        first_pend_d = first_pend_q;
        error_d      = 1'b0;
        overflow_d   = 1'b0;
        valid_d      = valid_q && !ready;
        first_d      = first_q;
        green_d      = green_q;
        red_d        = red_q;
        blue_d       = blue_q;

        case (state_q)
            ST_SYNC: begin
                if (!ds && run >= RESET_MIN_C) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                first_pend_d = 1'b1;
                bitcnt_d     = '0;
                if (rise) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (fall) begin
                    if (cnt_q < MIN_HI_C || cnt_q > MAX_HI_C) begin
                        error_d  = 1'b1;
                        bitcnt_d = '0;
                        state_d  = ST_SYNC;
                    end else begin
                        sr_d    = word[CNT_COLOR-2:0];
                        state_d = ST_LO;
                        if (bitcnt_q == LAST_BIT_C) begin
                            bitcnt_d = '0;
                            done     = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q + BW'(1);
                        end
                    end
                end else if (run > MAX_HI_C) begin
                    // Line stuck high: give up now rather than wait for a fall.
                    error_d  = 1'b1;
                    bitcnt_d = '0;
                    state_d  = ST_SYNC;
                end
            end
            ST_LO: begin
                if (rise) begin
                    state_d = ST_HI;
                end else if (run >= RESET_MIN_C) begin
                    state_d = ST_GAP;
                    if (bitcnt_q != '0) begin
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        // The buffer counts as free when it is empty or being drained this
        // cycle, so a pixel landing on the accept cycle goes out back-to-back.
        if (done) begin
            first_pend_d = 1'b0;
            if (!valid_q || ready) begin
                green_d = word[23:16];
                red_d   = word[15:8];
                blue_d  = word[7:0];
                first_d = first_pend_q;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            cnt_q        <= '0;
            bitcnt_q     <= '0;
            sr_q         <= '0;
            first_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            green_q      <= '0;
            red_q        <= '0;
            blue_q       <= '0;
            error_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitcnt_q     <= bitcnt_d;
            sr_q         <= sr_d;
            first_pend_q <= first_pend_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            green_q      <= green_d;
            red_q        <= red_d;
            blue_q       <= blue_d;
            error_q      <= error_d;
            overflow_q   <= overflow_d;
        end
    end

    assign green    = green_q;
    assign red      = red_q;
    assign blue     = blue_q;
    assign first    = first_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign error    = error_q;
    assign in_gap   = (state_q == ST_GAP);

endmodule
